// File: rtl/alu_pkg.sv
// Shared types and constants for the chunked carry-lookahead add/sub unit.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunked_cla_addsub_if.sv
// Request/response bundle for the chunked add/sub unit: the master issues
// start with operands, the slave returns busy/done, result and flags.
interface chunked_cla_addsub_if #(
  parameter int WIDTH = alu_pkg::DEF_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow, zero, negative
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow, zero, negative
  );

endinterface

// File: rtl/cla_chunk.sv
// Combinational CHUNK-bit carry-lookahead adder slice; every carry is
// expanded directly from generate/propagate terms and the chunk carry-in.
module cla_chunk #(
  parameter int CHUNK = alu_pkg::DEF_CHUNK
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             c_msb_in,
  output logic             c_out
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = cin;

  genvar gi, gj;
  for (gi = 0; gi < CHUNK; gi++) begin : g_carry
    // terms[gj]: generate at bit gj propagated up to bit gi; top term is cin.
    logic [gi+1:0] terms;
    assign terms[gi+1] = cin & (&p[gi:0]);
    for (gj = 0; gj <= gi; gj++) begin : g_term
      if (gj == gi) begin : g_self
        assign terms[gj] = g[gj];
      end else begin : g_prop
        assign terms[gj] = g[gj] & (&p[gi:gj+1]);
      end
    end
    assign c[gi+1] = |terms;
  end

  assign s        = p ^ c[CHUNK-1:0];
  assign c_msb_in = c[CHUNK-1];
  assign c_out    = c[CHUNK];

endmodule

// File: rtl/chunked_cla_addsub.sv
// Multi-cycle WIDTH-bit add/sub: one CLA chunk per clock, LSB chunk first,
// with a registered carry between chunks and flags loaded at completion.
module chunked_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic               clk,
  input logic               rst,
  chunked_cla_addsub_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic             carry_reg;
  logic [IDXW-1:0]  idx_reg;

  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             zero_reg;
  logic             negative_reg;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] x_sel;
  logic [CHUNK-1:0] y_sel;
  logic [CHUNK-1:0] s_chunk;
  logic             c_msb_in;
  logic             c_out;

  // Chunk-select muxing and accumulator merge of the freshly computed slice.
  genvar gi;
  for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    assign acc_next[gi*CHUNK +: CHUNK] =
      (idx_reg == IDXW'(gi)) ? s_chunk : acc_reg[gi*CHUNK +: CHUNK];
  end

  assign x_sel = a_chunks[idx_reg];
  assign y_sel = b_chunks[idx_reg];

  cla_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x        (x_sel),
    .y        (y_sel),
    .cin      (carry_reg),
    .s        (s_chunk),
    .c_msb_in (c_msb_in),
    .c_out    (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      carry_reg    <= 1'b0;
      idx_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      negative_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            a_reg     <= bus.a;
            b_reg     <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            carry_reg <= (bus.sub == OP_SUB);
            idx_reg   <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= c_out;
          idx_reg   <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            result_reg   <= acc_next;
            cout_reg     <= c_out;
            overflow_reg <= c_msb_in ^ c_out;
            zero_reg     <= (acc_next == '0);
            negative_reg <= acc_next[WIDTH-1];
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.result   = result_reg;
  assign bus.cout     = cout_reg;
  assign bus.overflow = overflow_reg;
  assign bus.zero     = zero_reg;
  assign bus.negative = negative_reg;

endmodule

// File: doc/chunked_cla_addsub.md
Name: chunked_cla_addsub

Overview:
Multi-cycle, parametrised signed/unsigned adder-subtractor built around one carry-lookahead chunk. It processes a WIDTH-bit operation CHUNK bits per clock, LSB chunk first, and carries a registered ripple between chunks. It uses a start/busy/done handshake and adds a subtract mode plus carry, overflow, zero and negative flags. It sits in the datapath as the ALU add/sub unit where a full-width single-cycle CLA is too costly.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of CHUNK and at least CHUNK.
CHUNK, 4, bits processed per cycle by the CLA chunk.
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE or DONE.
sub  in  1  0 = a+b, 1 = a-b; sampled with start.
a  in  WIDTH  operand A; sampled with start.
b  in  WIDTH  operand B; sampled with start.
busy  out  1  high while state is RUN.
done  out  1  one-cycle pulse when results become valid.
result  out  WIDTH  registered sum/difference.
cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
overflow  out  1  two's-complement overflow = carry into MSB xor carry out.
zero  out  1  result == 0.
negative  out  1  result[WIDTH-1].

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, result, cout, overflow, zero, negative all 0; internal operand, carry and chunk-index registers 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge E0:
  - latch A=a, B = sub ? ~b : b, carry = sub, idx = 0;
  - clear the internal accumulator;
  - go to RUN.
- DONE + start=0: go to IDLE. IDLE + start=0: stay in IDLE.
- RUN, each edge E1..E_NCHUNK:
  - CLA chunk computes A[idx], B[idx] plus carry;
  - sum is written into accumulator chunk idx; carry register takes the chunk carry-out; idx increments.
- At edge E_NCHUNK (idx = NCHUNK-1):
  - result = full accumulator;
  - cout = chunk carry-out;
  - overflow = chunk carry-into-MSB xor carry-out;
  - zero and negative are derived from the final result;
  - all outputs are loaded together; state goes to DONE.
- done: high for exactly the one cycle the state is DONE, i.e. after edge E_NCHUNK. Latency from start-sampling edge to done visible is NCHUNK edges.
- Output hold: result and flags change only at the completion edge. They hold their values through IDLE and any following RUN until the next completion.
- start during RUN: ignored; no queuing.
- start in DONE: accepted (back-to-back operation). done still drops after one cycle because the state becomes RUN.
- Operands changing after the start edge: no effect.
- Reset mid-RUN: operation aborted, no done pulse, outputs return to 0.
- Unsigned and signed interpretations share one datapath. Results wrap modulo 2^WIDTH.

Decomposition:
- Shared package alu_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH and CHUNK constants;
  - op-mode constants OP_ADD=0, OP_SUB=1.
- Sub-module cla_chunk (purely combinational, parameter CHUNK):
  - inputs x, y, cin; outputs s, c_msb_in, c_out;
  - generate/propagate lookahead, instantiated once.
- The top level holds the FSM, operand/accumulator registers and the chunk-select muxing.

Test Plan:
1. WIDTH=16, CHUNK=4, add 0x1234 + 0x0FFF -> result 0x2233, cout 0, overflow 0, zero 0, negative 0; busy high for 4 cycles; done pulses once, 4 edges after start.
2. Add 0x7FFF + 0x0001 -> result 0x8000, overflow 1, negative 1, cout 0.
3. Subtract 0x0005 - 0x0005 -> result 0x0000, zero 1, cout 1, overflow 0.
4. Subtract 0x8000 - 0x0001 -> result 0x7FFF, overflow 1, cout 1, negative 0; then a back-to-back start asserted in the DONE cycle with add 0xFFFF + 0x0001 -> result 0x0000, cout 1, zero 1.
5. Pulse start again mid-RUN with different operands -> ignored, first result unchanged. Assert rst mid-RUN of a new operation -> busy and done 0, all outputs 0 immediately, no done pulse afterwards.
6. WIDTH=8, CHUNK=4, add 0xFF + 0x01 -> result 0x00, cout 1, zero 1, overflow 0; done 2 edges after start.
